// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads the instruction memory from an 8-bit byte stream.
// Frame format: header byte N (word count), then 4*N data bytes, with each
// word sent little-endian. The CPU is held on a NOP until a load finishes
// cleanly. While a load runs, the loader owns the write port. The fetch
// path is passed through whenever the core is released.
// Optional build macro IMEM_CHECKSUM_EN: after the data bytes, a trailer
// byte equal to the XOR of all data bytes is required (state CHK).
module imem_boot_loader #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       pc,
  output logic [ADDR_W-1:0] imem_raddr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr_out,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

`ifdef IMEM_CHECKSUM_EN
  typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_FLUSH, ST_CHK, ST_RUN, ST_ERR} state_t;
`else
  typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_FLUSH, ST_RUN, ST_ERR} state_t;
`endif

  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  state_t              state;
  state_t              next_state;
  logic                armed;      // low only while in reset; keeps rx_ready low until the first clock after reset
  logic [7:0]          n_words;
  logic [ADDR_W-1:0]   word_cnt;
  logic [1:0]          byte_cnt;
  logic [23:0]         asm_word;   // the first three bytes of the current word, newest byte at the top
  logic                accept;
  logic                word_done;
  logic                last_word;
  logic                hdr_too_big;
  logic                unused_pc_bits;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]          chk_acc;
`endif

  assign accept         = rx_valid && rx_ready;
  assign word_done      = accept && (state == ST_DATA) && (byte_cnt == 2'd3);
  assign last_word      = (8'(word_cnt) == (n_words - 8'd1));
  assign hdr_too_big    = ({1'b0, rx_data} > DEPTH_LIM);
  assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_HDR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_HDR: begin
        if (accept) begin
          if (rx_data == 8'd0) begin
`ifdef IMEM_CHECKSUM_EN
            next_state = ST_CHK;
`else
            next_state = ST_RUN;
`endif
          end else if (hdr_too_big) begin
            next_state = ST_ERR;
          end else begin
            next_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_done && last_word) begin
          next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
`ifdef IMEM_CHECKSUM_EN
        next_state = ST_CHK;
`else
        next_state = ST_RUN;
`endif
      end
`ifdef IMEM_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          next_state = (rx_data == chk_acc) ? ST_RUN : ST_ERR;
        end
      end
`endif
      ST_RUN, ST_ERR: begin
        if (reload) begin
          next_state = ST_HDR;
        end
      end
      default: next_state = ST_HDR;
    endcase
  end

  // Output decode: handshake, hold and status follow the current state
  always_comb begin
    rx_ready   = 1'b0;
    cpu_hold   = (state != ST_RUN);
    load_done  = (state == ST_RUN);
    load_err   = (state == ST_ERR);
    imem_raddr = pc[ADDR_W+1:2];
    instr_out  = imem_rdata;
    case (state)
`ifdef IMEM_CHECKSUM_EN
      ST_HDR, ST_DATA, ST_CHK: rx_ready = armed;
`else
      ST_HDR, ST_DATA:         rx_ready = armed;
`endif
      default:                 rx_ready = 1'b0;
    endcase
    if (cpu_hold) begin
      instr_out = NOP_WORD;
    end
  end

  // Datapath: header latch, word assembly and the registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      n_words    <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      asm_word   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
`ifdef IMEM_CHECKSUM_EN
      chk_acc    <= '0;
`endif
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;
      case (state)
        ST_HDR: begin
          if (accept) begin
            n_words  <= rx_data;
            word_cnt <= '0;
            byte_cnt <= '0;
`ifdef IMEM_CHECKSUM_EN
            chk_acc  <= '0;
`endif
          end
        end
        ST_DATA: begin
          if (accept) begin
            asm_word <= {rx_data, asm_word[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_CHECKSUM_EN
            chk_acc  <= chk_acc ^ rx_data;
`endif
            // Write register is separate from asm_word so the next word's
            // first byte can be taken in the same cycle as this strobe.
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_waddr <= word_cnt;
              imem_wdata <= {rx_data, asm_word};
              word_cnt   <= word_cnt + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (DEPTH 32, ADDR_W 5).
// Honours IMEM_CHECKSUM_EN when it is defined for the build.
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        reload;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [4:0]  imem_raddr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int          checks;
  int          errors;
  int          base;
  logic [4:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  logic [7:0]  ld1 [8] = '{8'h33, 8'h89, 8'h08, 8'h01, 8'h33, 8'h09, 8'hF8, 8'h00};
  logic [7:0]  tog [4] = '{8'h13, 8'h00, 8'h00, 8'h00};
  logic [7:0]  part[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  fresh[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0]  ck  [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  imem_boot_loader #(
    .DEPTH   (32),
    .ADDR_W  (5),
    .NOP_WORD(32'h00000013)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reload    (reload),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .pc        (pc),
    .imem_raddr(imem_raddr),
    .imem_rdata(imem_rdata),
    .instr_out (instr_out),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture every write strobe shortly after the edge that produced it
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wq_addr.push_back(imem_waddr);
      wq_data.push_back(imem_wdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx < wq_addr.size()) begin
      chk("wr_addr", 32'(wq_addr[idx]), addr);
      chk("wr_data", wq_data[idx], data);
    end else begin
      checks++;
      errors++;
      $error("FAIL wr_missing: observed %0d writes expected index %0d", wq_addr.size(), idx);
    end
  endtask

  // Called at a negedge; the byte is taken on the next posedge and the task returns at the following negedge
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Called at the FLUSH negedge; returns once the load has ended in RUN or ERR
  task automatic finish_load(input logic [7:0] trailer);
    @(negedge clk);
`ifdef IMEM_CHECKSUM_EN
    chk("chk_ready", 32'(rx_ready), 32'd1);
    send_byte(trailer);
`else
    chk("post_flush_trailer_unused", 32'(trailer & 8'h00), 32'd0);
`endif
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; reload = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    pc = 32'h0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_waddr", 32'(imem_waddr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    reset = 1'b0;
    #1 chk("ready_low_at_release", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(rx_ready), 32'd1);

    // NOP substitution while held
    pc = 32'h8; imem_rdata = 32'hDEADBEEF;
    #1;
    chk("held_instr", instr_out, 32'h00000013);
    chk("held_raddr", 32'(imem_raddr), 32'd2);
    @(negedge clk);

    // N=2 load at one byte per cycle
    base = wq_addr.size();
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(ld1[i]);
    chk("flush_we", 32'(imem_we), 32'd1);
    chk("flush_hold", 32'(cpu_hold), 32'd1);
    chk("flush_ready", 32'(rx_ready), 32'd0);
    chk("flush_done", 32'(load_done), 32'd0);
    finish_load(8'h71);
    chk("run_hold", 32'(cpu_hold), 32'd0);
    chk("run_done", 32'(load_done), 32'd1);
    chk("run_we", 32'(imem_we), 32'd0);
    chk("run_ready", 32'(rx_ready), 32'd0);
    chk("run_instr", instr_out, 32'hDEADBEEF);
    chk("ld1_count", 32'(wq_addr.size()), 32'(base + 2));
    check_write(base, 32'd0, 32'h01088933);
    check_write(base + 1, 32'd1, 32'h00F80933);

    // Bytes in RUN are ignored
    base = wq_addr.size();
    send_byte(8'h55);
    send_byte(8'hAA);
    chk("run_ignore_done", 32'(load_done), 32'd1);
    chk("run_ignore_writes", 32'(wq_addr.size()), 32'(base));

    // Oversize header -> ERR
    pulse_reload();
    chk("reload_hold", 32'(cpu_hold), 32'd1);
    chk("reload_done", 32'(load_done), 32'd0);
    chk("reload_ready", 32'(rx_ready), 32'd1);
    send_byte(8'd33);
    repeat (2) @(negedge clk);
    chk("err_flag", 32'(load_err), 32'd1);
    chk("err_ready", 32'(rx_ready), 32'd0);
    chk("err_hold", 32'(cpu_hold), 32'd1);
    chk("err_writes", 32'(wq_addr.size()), 32'(base));

    // Empty load
    pulse_reload();
    chk("reload_err_clear", 32'(load_err), 32'd0);
    send_byte(8'h00);
`ifdef IMEM_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("n0_done", 32'(load_done), 32'd1);
    chk("n0_writes", 32'(wq_addr.size()), 32'(base));

    // Full-depth load, N = DEPTH
    pulse_reload();
    base = wq_addr.size();
    send_byte(8'd32);
    for (int k = 0; k < 128; k++) send_byte(8'(k));
    chk("full_flush_we", 32'(imem_we), 32'd1);
    finish_load(8'h00);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_count", 32'(wq_addr.size()), 32'(base + 32));
    for (int i = 0; i < 32; i++)
      check_write(base + i, 32'(i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});

    // Throttled stream; a reload in DATA must be ignored
    pulse_reload();
    base = wq_addr.size();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) begin
      send_byte(tog[i]);
      if (i < 3) begin
        reload = (i == 1);
        @(negedge clk);
        reload = 1'b0;
        chk("tog_ready", 32'(rx_ready), 32'd1);
      end
    end
    chk("tog_flush_we", 32'(imem_we), 32'd1);
    finish_load(8'h13);
    chk("tog_done", 32'(load_done), 32'd1);
    chk("tog_count", 32'(wq_addr.size()), 32'(base + 1));
    check_write(base, 32'd0, 32'h00000013);

    // Reset in the middle of an N=3 load
    pulse_reload();
    base = wq_addr.size();
    send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(part[i]);
    reset = 1'b1;
    #1;
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_waddr", 32'(imem_waddr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_done", 32'(load_done), 32'd0);
    chk("mid_rst_err", 32'(load_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_partial", 32'(wq_addr.size()), 32'(base + 1));
    check_write(base, 32'd0, 32'h44332211);
    chk("fresh_ready", 32'(rx_ready), 32'd1);
    base = wq_addr.size();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(fresh[i]);
    finish_load(8'h00);
    chk("fresh_done", 32'(load_done), 32'd1);
    chk("fresh_count", 32'(wq_addr.size()), 32'(base + 1));
    check_write(base, 32'd0, 32'hDDCCBBAA);

    // Trailer match and mismatch (plain load when the trailer is not built)
    pulse_reload();
    base = wq_addr.size();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(ck[i]);
    finish_load(8'h0F);
    chk("ck_good_done", 32'(load_done), 32'd1);
    check_write(base, 32'd0, 32'h08040201);
`ifdef IMEM_CHECKSUM_EN
    pulse_reload();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(ck[i]);
    finish_load(8'h0E);
    chk("ck_bad_err", 32'(load_err), 32'd1);
    chk("ck_bad_done", 32'(load_done), 32'd0);
    chk("ck_bad_hold", 32'(cpu_hold), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
